// File: rtl/digitizer_scheduler_pkg.sv
// Shared types and constants for the digitizer scheduler: FSM state encoding
// and the converter bus widths.
package digitizer_scheduler_pkg;

    localparam int SEG_W = 14;
    localparam int VAL_W = 4;
    localparam logic [SEG_W-1:0] SEG_BLANK = 14'h3FFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_DONE   = 2'd3
    } sched_state_t;

endpackage

// File: rtl/digitizer_scheduler_if.sv
// Bundle between the value sources / shared converter (master) and the
// scheduler (slave).
interface digitizer_scheduler_if
    import digitizer_scheduler_pkg::*;
#(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0]       req;
    logic [VAL_W*NUM_CH-1:0] value;
    logic [NUM_CH-1:0]       ack;
    logic [VAL_W-1:0]        conv_in;
    logic [SEG_W-1:0]        conv_out;
    logic [SEG_W*NUM_CH-1:0] seg_out;
    logic [NUM_CH-1:0]       seg_valid;
    logic                    busy;

    modport master (
        output req, value, conv_out,
        input  ack, conv_in, seg_out, seg_valid, busy
    );

    modport slave (
        input  req, value, conv_out,
        output ack, conv_in, seg_out, seg_valid, busy
    );
endinterface

// File: rtl/digitizer_scheduler_rr_pick.sv
// Combinational round-robin picker: first requesting index after i_last_grant,
// wrapping modulo NUM_CH.
module rr_pick #(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0]         i_req,
    input  logic [$clog2(NUM_CH)-1:0] i_last_grant,
    output logic [$clog2(NUM_CH)-1:0] o_grant,
    output logic                      o_found
);
    localparam int IDX_W = $clog2(NUM_CH);

    // Walk from the farthest offset down so the nearest requester overwrites.
    always_comb begin
        o_grant = '0;
        o_found = 1'b0;
        for (int k = NUM_CH; k >= 1; k--) begin
            if (i_req[(int'(i_last_grant) + k) % NUM_CH]) begin
                o_grant = IDX_W'((int'(i_last_grant) + k) % NUM_CH);
                o_found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/digitizer_scheduler.sv
// Round-robin time-sharing of one external 2-digit 7-segment converter.
// Optional settle wait between drive and capture: DIGITIZER_SCHED_SETTLE_EN.
module digitizer_scheduler
    import digitizer_scheduler_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    digitizer_scheduler_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_CH);

    sched_state_t     r_state;
    sched_state_t     w_state_next;
    logic [IDX_W-1:0] r_grant;
    logic [IDX_W-1:0] r_last_grant;
    logic [IDX_W-1:0] w_grant;
    logic             w_found;
    logic             w_load;
    logic             w_capture;
    logic [VAL_W-1:0] r_conv_in;
    logic [VAL_W-1:0] w_val [NUM_CH];
    logic [NUM_CH-1:0] w_sel;

    rr_pick #(.NUM_CH(NUM_CH)) u_pick (
        .i_req        (bus.req),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_found      (w_found)
    );

`ifdef DIGITIZER_SCHED_SETTLE_EN
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    logic [CNT_W-1:0] r_settle_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_settle_cnt <= '0;
        end else if (r_state == ST_SETTLE) begin
            r_settle_cnt <= r_settle_cnt + CNT_W'(1);
        end else begin
            r_settle_cnt <= '0;
        end
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_load       = 1'b1;
                    w_state_next = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
`ifdef DIGITIZER_SCHED_SETTLE_EN
                if (SETTLE_CYCLES == 0) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_SETTLE;
                end
`else
                w_capture    = 1'b1;
                w_state_next = ST_DONE;
`endif
            end
            ST_SETTLE: begin
`ifdef DIGITIZER_SCHED_SETTLE_EN
                if (r_settle_cnt == CNT_LAST) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_DONE;
                end
`else
                w_state_next = ST_IDLE;
`endif
            end
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Value is sampled only at grant; conv_in then holds until the next grant.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_conv_in    <= '0;
            r_grant      <= '0;
            r_last_grant <= IDX_W'(NUM_CH - 1);
        end else begin
            if (w_load) begin
                r_conv_in <= w_val[w_grant];
                r_grant   <= w_grant;
            end
            if (r_state == ST_DONE) begin
                r_last_grant <= r_grant;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [SEG_W-1:0] r_seg;
            logic             r_valid;
            logic             r_ack;

            assign w_val[gi] = bus.value[gi*VAL_W +: VAL_W];
            assign w_sel[gi] = (r_grant == IDX_W'(gi));

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_seg   <= SEG_BLANK;
                    r_valid <= 1'b0;
                    r_ack   <= 1'b0;
                end else begin
                    r_ack <= w_capture && w_sel[gi];
                    if (w_capture && w_sel[gi]) begin
                        r_seg   <= bus.conv_out;
                        r_valid <= 1'b1;
                    end
                end
            end

            assign bus.seg_out[gi*SEG_W +: SEG_W] = r_seg;
            assign bus.seg_valid[gi]              = r_valid;
            assign bus.ack[gi]                    = r_ack;
        end

        if (NUM_CH < 2 || NUM_CH > 8 || SETTLE_CYCLES < 0) begin : g_bad_cfg
            $error("digitizer_scheduler: NUM_CH must be 2..8 and SETTLE_CYCLES >= 0");
        end
    endgenerate

    assign bus.conv_in = r_conv_in;
    assign bus.busy    = (r_state != ST_IDLE);
endmodule

// File: tb/tb_digitizer_scheduler.sv
// Scoreboard bench for digitizer_scheduler with a behavioural 2-digit converter.
module tb_digitizer_scheduler;
    import digitizer_scheduler_pkg::*;

    localparam int NCH = 4;
    localparam int SC  = 2;
`ifdef DIGITIZER_SCHED_SETTLE_EN
    localparam int LAT = 2 + SC;
`else
    localparam int LAT = 2;
`endif
    localparam int PER = LAT + 1;
    localparam logic [SEG_W*NCH-1:0] ALL_BLANK = {NCH{SEG_BLANK}};

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    digitizer_scheduler_if #(.NUM_CH(NCH)) bus();

    digitizer_scheduler #(.NUM_CH(NCH), .SETTLE_CYCLES(SC)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [6:0] seg7(input int d);
        case (d)
            0: seg7 = 7'b1000000;  1: seg7 = 7'b1111001;
            2: seg7 = 7'b0100100;  3: seg7 = 7'b0110000;
            4: seg7 = 7'b0011001;  5: seg7 = 7'b0010010;
            6: seg7 = 7'b0000010;  7: seg7 = 7'b1111000;
            8: seg7 = 7'b0000000;  9: seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    assign bus.conv_out = {seg7(int'(bus.conv_in) / 10), seg7(int'(bus.conv_in) % 10)};

    typedef struct {
        int         ch;
        logic [13:0] pat;
        logic [3:0]  val;
        int         cyc;
    } exp_t;

    exp_t           sb[$];
    exp_t           mon_e;
    int             n_vec = 0;
    int             n_err = 0;
    int             cyc   = 0;
    logic [13:0]    m_seg [NCH];
    logic [NCH-1:0] m_valid;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [SEG_W*NCH-1:0] model_seg();
        logic [SEG_W*NCH-1:0] r;
        for (int i = 0; i < NCH; i++) r[i*SEG_W +: SEG_W] = m_seg[i];
        return r;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < NCH; i++) m_seg[i] = SEG_BLANK;
        m_valid = '0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ack"},       64'(bus.ack),       64'(0));
        chk({tag, "_conv_in"},   64'(bus.conv_in),   64'(0));
        chk({tag, "_seg_out"},   64'(bus.seg_out),   64'(ALL_BLANK));
        chk({tag, "_seg_valid"}, 64'(bus.seg_valid), 64'(0));
        chk({tag, "_busy"},      64'(bus.busy),      64'(0));
    endtask

    // Monitor: every ack is matched against the oldest expected conversion.
    always @(negedge clock) begin
        if (!reset && bus.ack != '0) begin
            chk("ack_onehot", 64'($onehot(bus.ack)), 64'(1));
            if (sb.size() == 0) begin
                chk("unexpected_ack", 64'(bus.ack), 64'(0));
            end else begin
                mon_e = sb.pop_front();
                chk("ack_channel", 64'(bus.ack), 64'(1) << mon_e.ch);
                chk("ack_cycle",   64'(cyc), 64'(mon_e.cyc));
                chk("conv_in_held", 64'(bus.conv_in), 64'(mon_e.val));
                chk("seg_pattern", 64'(bus.seg_out[mon_e.ch*SEG_W +: SEG_W]), 64'(mon_e.pat));
                m_seg[mon_e.ch]   = mon_e.pat;
                m_valid[mon_e.ch] = 1'b1;
                chk("seg_out_all", 64'(bus.seg_out),   64'(model_seg()));
                chk("seg_valid",   64'(bus.seg_valid), 64'(m_valid));
                $display("ack ch%0d val=%0d seg=%b_%b cycle=%0d", mon_e.ch, mon_e.val,
                         bus.seg_out[mon_e.ch*SEG_W+7 +: 7], bus.seg_out[mon_e.ch*SEG_W +: 7], cyc);
            end
        end
    end

    task automatic wait_ack(input int ch);
        bit found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clock);
            if (bus.ack[ch]) found = 1'b1;
        end
        if (!found) chk($sformatf("ack_timeout_ch%0d", ch), 64'(bus.ack), 64'(1) << ch);
    endtask

    task automatic single(input int ch, input logic [3:0] v, input logic [13:0] pat);
        @(negedge clock);
        sb.push_back('{ch, pat, v, cyc + LAT});
        bus.value[ch*VAL_W +: VAL_W] = v;
        bus.req[ch] = 1'b1;
        wait_ack(ch);
        bus.req[ch] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int hits;
        logic [13:0] rr_pat [NCH];
        logic [3:0]  rr_val [NCH];
        rr_val = '{4'd1, 4'd4, 4'd10, 4'd15};
        rr_pat = '{14'b1000000_1111001, 14'b1000000_0011001,
                   14'b1111001_1000000, 14'b1111001_0010010};

        bus.req   = '0;
        bus.value = '0;
        clear_model();
        repeat (3) @(negedge clock);
        check_reset("in_reset");
        reset = 1'b0;
        @(negedge clock);
        check_reset("after_reset");

        single(0, 4'd7,  14'b1000000_1111000);
        single(2, 4'd12, 14'b1111001_0100100);

        // value changes after grant must not affect the captured pattern
        @(negedge clock);
        sb.push_back('{1, 14'b1000000_0010010, 4'd5, cyc + LAT});
        bus.value[7:4] = 4'd5;
        bus.req[1]     = 1'b1;
        @(negedge clock);
        bus.value[7:4] = 4'd9;
        wait_ack(1);
        bus.req[1] = 1'b0;

        // req dropped one cycle after grant still completes
        @(negedge clock);
        sb.push_back('{3, 14'b1000000_0110000, 4'd3, cyc + LAT});
        bus.value[15:12] = 4'd3;
        bus.req[3]       = 1'b1;
        @(negedge clock);
        bus.req[3] = 1'b0;
        wait_ack(3);

        single(0, 4'd0, 14'b1000000_1000000);

        // asynchronous reset while the FSM is busy
        @(negedge clock);
        bus.value[11:8] = 4'd9;
        bus.req[2]      = 1'b1;
        @(negedge clock);
        chk("busy_before_abort", 64'(bus.busy), 64'(1));
        reset = 1'b1;
        #1;
        check_reset("mid_drive");
        clear_model();
        bus.req[2] = 1'b0;
        @(negedge clock);
        reset = 1'b0;

        // ch0 and ch2 together: ch0 wins after reset
        @(negedge clock);
        c = cyc;
        sb.push_back('{0, 14'b1000000_0000010, 4'd6, c + LAT});
        sb.push_back('{2, 14'b1000000_0000000, 4'd8, c + LAT + PER});
        bus.value[3:0]  = 4'd6;
        bus.value[11:8] = 4'd8;
        bus.req[0] = 1'b1;
        bus.req[2] = 1'b1;
        wait_ack(0);
        bus.req[0] = 1'b0;
        wait_ack(2);
        bus.req[2] = 1'b0;

        // all channels held from reset: strict rotation 0,1,2,3,0,1,2,3
        @(negedge clock);
        reset = 1'b1;
        clear_model();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        c = cyc;
        for (int i = 0; i < NCH; i++) bus.value[i*VAL_W +: VAL_W] = rr_val[i];
        for (int k = 0; k < 2 * NCH; k++)
            sb.push_back('{k % NCH, rr_pat[k % NCH], rr_val[k % NCH], c + LAT + PER * k});
        bus.req = '1;
        hits = 0;
        for (int k = 0; k < 100 && hits < 2; k++) begin
            @(negedge clock);
            if (bus.ack[NCH-1]) hits++;
        end
        bus.req = '0;
        if (hits < 2) chk("rr_timeout", 64'(hits), 64'(2));

        repeat (10) @(negedge clock);
        chk("scoreboard_empty", 64'(sb.size()), 64'(0));
        chk("final_idle", 64'(bus.busy), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/digitizer_scheduler.md
Name: digitizer_scheduler

Overview:
Time-shares one binary-to-two-digit 7-segment converter (4-bit in, 14-bit segment pattern out, tens digit in [13:7], ones digit in [6:0]) between NUM_CH requesters. A round-robin FSM grants one channel at a time, drives the converter input, captures its output and holds one registered 14-bit pattern per channel for the HEX displays. Sits between the value sources (switches, counters) and the DE2-115 HEX pins; the converter instance lives outside this block.

Parameters:
NUM_CH, 4, number of requesting channels (2..8)
SETTLE_CYCLES, 2, extra converter settle cycles; used only with DIGITIZER_SCHED_SETTLE_EN

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
req  input  NUM_CH  per-channel conversion request, level, held until ack
value  input  4*NUM_CH  channel i value in bits [4i+3:4i]
ack  output  NUM_CH  one-cycle pulse: channel i pattern updated
conv_in  output  4  registered drive to shared converter input
conv_out  input  14  converter result (combinational from conv_in)
seg_out  output  14*NUM_CH  channel i pattern in [14i+13:14i], active-low segments
seg_valid  output  NUM_CH  channel i has been converted since reset
busy  output  1  FSM not in IDLE

Behaviour:
- Reset: is asynchronous, active-high and applies immediately, including mid-operation. Outputs after reset: ack=0, conv_in=0, seg_out all 1s (all segments blank), seg_valid=0, busy=0, state=IDLE, last_grant=NUM_CH-1 (channel 0 wins first).
- States: IDLE -> DRIVE -> DONE -> IDLE.
- IDLE: if any req bit is high, grant = first requesting index searching last_grant+1, last_grant+2, ... modulo NUM_CH. On that edge: register conv_in <= value[grant], latch grant, go DRIVE. If no request, stay in IDLE.
- DRIVE: busy=1; conv_out is valid in this cycle. At the edge: seg_out[grant] <= conv_out, seg_valid[grant] <= 1, ack[grant] <= 1, go DONE.
- DONE: ack[grant]=1 for exactly this cycle; last_grant <= grant; go IDLE. Earliest next grant is in the following IDLE cycle.
- Latency: req seen high in IDLE cycle T, then ack high in cycle T+2, with seg_out updated in the same cycle as ack. Throughput is one conversion per 3 cycles.
- value is sampled only at grant. Later changes are ignored until the next request.
- Dropping req after grant does not abort; the conversion completes and acks. Dropping req before grant means the channel is not served.
- Holding req high through ack re-requests the channel. Round-robin lets every other pending channel be served first (no starvation; worst wait (NUM_CH-1)*3 cycles).
- Values 10..15 pass through unchanged; the converter defines the pattern.
- Only one ack bit is ever high. Non-granted seg_out entries hold their value.

Optional Feature:
DIGITIZER_SCHED_SETTLE_EN:
- Defined: a SETTLE state is inserted between DRIVE and capture. The FSM waits SETTLE_CYCLES extra cycles with conv_in held, and capture happens on the last settle cycle. Latency becomes 2+SETTLE_CYCLES. SETTLE_CYCLES=0 behaves as undefined.
- Undefined: no SETTLE state and no settle counter logic; latency is fixed at 2.

Decomposition:
- Shared package: state encoding enum (IDLE, DRIVE, SETTLE, DONE), SEG_W=14, VAL_W=4, SEG_BLANK=14'h3FFF.
- Sub-module rr_pick: combinational round-robin priority picker taking req and last_grant, returning grant index and a found flag. Reused by future arbiters.

Test Plan:
- Reset mid-DRIVE (reset pulse while busy=1): all outputs return to reset values at once; ack never fires for the aborted conversion; a following ch0 request is served first.
- Single request, ch0 value=7, bench converter model: ack[0] high exactly 2 cycles after req seen; seg_out[13:0] = {7'b1000000, 7'b1111000}; seg_valid=0001.
- ch2 value=12: seg_out[41:28] = {7'b1111001, 7'b0100100}; all other seg_out entries stay 14'h3FFF.
- All four req held high from reset: ack order 0,1,2,3,0,...; acks 3 cycles apart; never two ack bits high together.
- ch1 value changes 5 -> 9 during DRIVE: captured pattern is for 5. ch3 req dropped one cycle after grant: ack[3] still pulses.
- With DIGITIZER_SCHED_SETTLE_EN, SETTLE_CYCLES=2: single request acks at T+4. conv_in stays stable from grant until ack.
